// File: rtl/minisys_ctrl_pkg.sv
// Shared definitions for the Minisys-1A multi-cycle control sequencer.
// Contents:
//   state_t        - FSM state encoding (the value is visible on the state port)
//   pc_src_t       - next-PC select encoding
//   EXC_*          - CP0 Cause ExcCode values
//   OP_* / F_* ... - opcode, funct and field constants used by the decoder
//   instr_class_t  - one-hot instruction class flags plus a reserved flag
package minisys_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EXE  = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_EXC  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    PC_4   = 3'd0,
    PC_BR  = 3'd1,
    PC_JMP = 3'd2,
    PC_REG = 3'd3,
    PC_EPC = 3'd4,
    PC_VEC = 3'd5
  } pc_src_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_COP0   = 6'b010000;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] F_SLL     = 6'b000000;
  localparam logic [5:0] F_SRL     = 6'b000010;
  localparam logic [5:0] F_SRA     = 6'b000011;
  localparam logic [5:0] F_SLLV    = 6'b000100;
  localparam logic [5:0] F_SRLV    = 6'b000110;
  localparam logic [5:0] F_SRAV    = 6'b000111;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_JALR    = 6'b001001;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_BREAK   = 6'b001101;
  localparam logic [5:0] F_MFHI    = 6'b010000;
  localparam logic [5:0] F_MTHI    = 6'b010001;
  localparam logic [5:0] F_MFLO    = 6'b010010;
  localparam logic [5:0] F_MTLO    = 6'b010011;
  localparam logic [5:0] F_MULT    = 6'b011000;
  localparam logic [5:0] F_MULTU   = 6'b011001;
  localparam logic [5:0] F_DIV     = 6'b011010;
  localparam logic [5:0] F_DIVU    = 6'b011011;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_ADDU    = 6'b100001;
  localparam logic [5:0] F_SUB     = 6'b100010;
  localparam logic [5:0] F_SUBU    = 6'b100011;
  localparam logic [5:0] F_AND     = 6'b100100;
  localparam logic [5:0] F_OR      = 6'b100101;
  localparam logic [5:0] F_XOR     = 6'b100110;
  localparam logic [5:0] F_NOR     = 6'b100111;
  localparam logic [5:0] F_SLT     = 6'b101010;
  localparam logic [5:0] F_SLTU    = 6'b101011;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // COP0 rs codes and the single legal eret word
  localparam logic [4:0]  RS_MFC0  = 5'b00000;
  localparam logic [4:0]  RS_MTC0  = 5'b00100;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  typedef struct packed {
    logic alu;       // anything that simply writes back a result
    logic branch;    // beq/bne/bgez/bgtz/blez/bltz
    logic link_br;   // bgezal/bltzal
    logic jmp;
    logic jal;
    logic jr;
    logic jalr;
    logic eret;
    logic mthilo;
    logic mtc0;
    logic mul;
    logic div;
    logic load;
    logic store;
    logic syscall;
    logic brk;
    logic reserved;
  } instr_class_t;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier for the Minisys-1A control sequencer.
// Ports:
//   ir  in  32  instruction register contents
//   cls out     one-hot class flags; exactly one bit set, reserved when the
//               encoding is outside the implemented ISA
module instr_class_dec
  import minisys_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_t cls
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign funct = ir[5:0];

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_JR:               cls.jr      = 1'b1;
          F_JALR:             cls.jalr    = 1'b1;
          F_MULT, F_MULTU:    cls.mul     = 1'b1;
          F_DIV, F_DIVU:      cls.div     = 1'b1;
          F_MTHI, F_MTLO:     cls.mthilo  = 1'b1;
          F_SYSCALL:          cls.syscall = 1'b1;
          F_BREAK:            cls.brk     = 1'b1;
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_MFHI, F_MFLO,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:      cls.alu     = 1'b1;
          default:            cls.reserved = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     cls.branch   = 1'b1;
          RT_BLTZAL, RT_BGEZAL: cls.link_br  = 1'b1;
          default:              cls.reserved = 1'b1;
        endcase
      end
      OP_COP0: begin
        if (ir == ERET_WORD)    cls.eret     = 1'b1;
        else if (rs == RS_MFC0) cls.alu      = 1'b1;
        else if (rs == RS_MTC0) cls.mtc0     = 1'b1;
        else                    cls.reserved = 1'b1;
      end
      OP_J:                               cls.jmp    = 1'b1;
      OP_JAL:                             cls.jal    = 1'b1;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:   cls.branch = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI:           cls.alu    = 1'b1;
      OP_LUI: begin
        // lui is only legal with a zero rs field
        if (rs == 5'd0) cls.alu      = 1'b1;
        else            cls.reserved = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls.load  = 1'b1;
      OP_SB, OP_SH, OP_SW:                 cls.store = 1'b1;
      default:                             cls.reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl32.sv
// Multi-cycle control sequencer for the Minisys-1A CPU.
// Steps the instruction in IR through IF/ID/EXE/MEM/WB, with memory wait
// states, multi-cycle mult/div dwell and exception/interrupt entry at
// instruction boundaries.
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   ir                        current IR contents
//   imem_ready, dmem_ready    instruction fetch / data access handshakes
//   Alu_resultHigh            effective-address high bits (IO decode)
//   branch_taken              branch condition, valid in EXE
//   int_req, int_en           external interrupt request and enable
//   state                     current FSM state
//   pc_write .. cp0_write     write enables
//   mem_*/io_*                data access strobes
//   muldiv_start              first-EXE-cycle pulse for mult/div
//   pc_src                    next-PC select
//   exc_req, exc_code         exception entry pulse and Cause ExcCode
//   instr_done                instruction retires this cycle
module multicycle_ctrl32
  import minisys_ctrl_pkg::*;
#(
  parameter int                   ADDR_HI_W  = 22,
  parameter logic [ADDR_HI_W-1:0] IO_HIGH    = '1,
  parameter int                   MUL_CYCLES = 4,
  parameter int                   DIV_CYCLES = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          ir,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic [ADDR_HI_W-1:0] Alu_resultHigh,
  input  logic                 branch_taken,
  input  logic                 int_req,
  input  logic                 int_en,
  output logic [2:0]           state,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 hilo_write,
  output logic                 cp0_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 io_read,
  output logic                 io_write,
  output logic                 muldiv_start,
  output logic [2:0]           pc_src,
  output logic                 exc_req,
  output logic [4:0]           exc_code,
  output logic                 instr_done
);

  localparam int              CNT_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] dwell_q;
  logic [4:0]       exc_code_q;

  instr_class_t     cls;
  logic             muldiv_op;
  logic             io_sel;
  logic             end_cycle;
  logic             take_int;
  pc_src_t          pc_src_c;

  instr_class_dec u_dec (
    .ir  (ir),
    .cls (cls)
  );

  assign muldiv_op = cls.mul | cls.div;
  assign io_sel    = (Alu_resultHigh == IO_HIGH);
  assign take_int  = int_req & int_en;

  // The cycle on which the current instruction retires.
  always_comb begin
    end_cycle = 1'b0;
    case (state_q)
      ST_EXE: end_cycle = cls.branch | cls.jmp | cls.jr | cls.eret |
                          cls.mthilo | cls.mtc0 |
                          (muldiv_op && (dwell_q == '0));
      ST_MEM: end_cycle = cls.store & dmem_ready;
      ST_WB:  end_cycle = 1'b1;
      default: end_cycle = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      dwell_q    <= '0;
      exc_code_q <= EXC_INT;
    end else begin
      case (state_q)
        ST_INIT: state_q <= ST_IF;
        ST_IF:   if (imem_ready) state_q <= ST_ID;
        ST_ID: begin
          if (cls.reserved) begin
            state_q    <= ST_EXC;
            exc_code_q <= EXC_RI;
          end else if (cls.syscall) begin
            state_q    <= ST_EXC;
            exc_code_q <= EXC_SYS;
          end else if (cls.brk) begin
            state_q    <= ST_EXC;
            exc_code_q <= EXC_BP;
          end else begin
            state_q <= ST_EXE;
            dwell_q <= cls.div ? DIV_LOAD : (cls.mul ? MUL_LOAD : '0);
          end
        end
        ST_EXE: begin
          if (muldiv_op) begin
            if (dwell_q != '0) dwell_q <= dwell_q - 1'b1;
          end else if (cls.load | cls.store) begin
            state_q <= ST_MEM;
          end else if (cls.alu | cls.link_br | cls.jal | cls.jalr) begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: if (dmem_ready && cls.load) state_q <= ST_WB;
        ST_WB:  ;
        ST_EXC: state_q <= ST_IF;
        default: state_q <= ST_INIT;
      endcase

      // Instruction boundary: this overrides the per-state choice above, and
      // is the only place an interrupt is ever sampled.
      if (end_cycle) begin
        if (take_int) begin
          state_q    <= ST_EXC;
          exc_code_q <= EXC_INT;
        end else begin
          state_q <= ST_IF;
        end
      end
    end
  end

  // Output decode; everything is forced quiet while reset is held so that an
  // aborted instruction issues no write on the reset cycle.
  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    hilo_write   = 1'b0;
    cp0_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    io_read      = 1'b0;
    io_write     = 1'b0;
    muldiv_start = 1'b0;
    exc_req      = 1'b0;
    pc_src_c     = PC_4;
    instr_done   = 1'b0;
    if (reset_n) begin
      instr_done = end_cycle;
      case (state_q)
        ST_IF: begin
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        ST_EXE: begin
          if (cls.branch | cls.link_br) begin
            pc_write = branch_taken;
            pc_src_c = PC_BR;
          end else if (cls.jmp | cls.jal) begin
            pc_write = 1'b1;
            pc_src_c = PC_JMP;
          end else if (cls.jr | cls.jalr) begin
            pc_write = 1'b1;
            pc_src_c = PC_REG;
          end else if (cls.eret) begin
            pc_write = 1'b1;
            pc_src_c = PC_EPC;
          end else if (cls.mthilo) begin
            hilo_write = 1'b1;
          end else if (cls.mtc0) begin
            cp0_write = 1'b1;
          end else if (muldiv_op) begin
            // Counter only ever counts down from its load value, so matching
            // the load value identifies the first dwell cycle.
            muldiv_start = (dwell_q == (cls.div ? DIV_LOAD : MUL_LOAD));
            hilo_write   = (dwell_q == '0);
          end
        end
        ST_MEM: begin
          io_read   = cls.load  &  io_sel;
          mem_read  = cls.load  & ~io_sel;
          io_write  = cls.store &  io_sel;
          mem_write = cls.store & ~io_sel;
        end
        ST_WB: reg_write = 1'b1;
        ST_EXC: begin
          exc_req  = 1'b1;
          pc_write = 1'b1;
          pc_src_c = PC_VEC;
        end
        default: ;
      endcase
    end
  end

  assign state    = state_q;
  assign pc_src   = pc_src_c;
  assign exc_code = exc_code_q;

endmodule

// File: tb/tb_multicycle_ctrl32.sv
// Directed bench for multicycle_ctrl32: each cycle sets inputs, then checks
// state, the packed strobe vector and pc_src against hand-computed values.
module tb_multicycle_ctrl32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic [21:0] Alu_resultHigh = 22'd0;
  logic        branch_taken = 1'b0;
  logic        int_req = 1'b0;
  logic        int_en = 1'b0;

  logic [2:0]  state;
  logic        pc_write, ir_write, reg_write, hilo_write, cp0_write;
  logic        mem_read, mem_write, io_read, io_write;
  logic        muldiv_start, exc_req, instr_done;
  logic [2:0]  pc_src;
  logic [4:0]  exc_code;
  logic [11:0] flags;

  // Strobe bit masks for the packed flags vector
  localparam logic [11:0] PW   = 12'h800;
  localparam logic [11:0] IRW  = 12'h400;
  localparam logic [11:0] RW   = 12'h200;
  localparam logic [11:0] HW   = 12'h100;
  localparam logic [11:0] CW   = 12'h080;
  localparam logic [11:0] MR   = 12'h040;
  localparam logic [11:0] MW   = 12'h020;
  localparam logic [11:0] IOR  = 12'h010;
  localparam logic [11:0] IOW  = 12'h008;
  localparam logic [11:0] MDS  = 12'h004;
  localparam logic [11:0] EXQ  = 12'h002;
  localparam logic [11:0] DONE = 12'h001;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_LW   = 32'h8C22_0000;
  localparam logic [31:0] I_SW   = 32'hAC22_0000;
  localparam logic [31:0] I_DIV  = 32'h0022_001A;
  localparam logic [31:0] I_BEQ  = 32'h1022_0004;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_RSV  = 32'hFC00_0000;
  localparam logic [31:0] I_SYSC = 32'h0000_000C;

  assign flags = {pc_write, ir_write, reg_write, hilo_write, cp0_write,
                  mem_read, mem_write, io_read, io_write,
                  muldiv_start, exc_req, instr_done};

  multicycle_ctrl32 #(
    .ADDR_HI_W  (22),
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ir             (ir),
    .imem_ready     (imem_ready),
    .dmem_ready     (dmem_ready),
    .Alu_resultHigh (Alu_resultHigh),
    .branch_taken   (branch_taken),
    .int_req        (int_req),
    .int_en         (int_en),
    .state          (state),
    .pc_write       (pc_write),
    .ir_write       (ir_write),
    .reg_write      (reg_write),
    .hilo_write     (hilo_write),
    .cp0_write      (cp0_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .io_read        (io_read),
    .io_write       (io_write),
    .muldiv_start   (muldiv_start),
    .pc_src         (pc_src),
    .exc_req        (exc_req),
    .exc_code       (exc_code),
    .instr_done     (instr_done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle (inputs already applied), then advance past the next edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] fl,
                     input logic [2:0] ps);
    #1;
    check({tag, ".state"},  32'(state),  32'(st));
    check({tag, ".flags"},  32'(flags),  32'(fl));
    check({tag, ".pc_src"}, 32'(pc_src), 32'(ps));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    cyc("rst", 3'd0, 12'h000, 3'd0);
    check("rst.exc_code", 32'(exc_code), 32'd0);

    reset_n = 1'b1;
    cyc("init", 3'd0, 12'h000, 3'd0);

    // addu with one fetch wait: IF, IF, ID, EXE, WB
    ir = I_ADDU;
    imem_ready = 1'b0;
    cyc("addu.ifwait", 3'd1, 12'h000, 3'd0);
    imem_ready = 1'b1;
    cyc("addu.if",  3'd1, PW | IRW,   3'd0);
    cyc("addu.id",  3'd2, 12'h000,    3'd0);
    cyc("addu.exe", 3'd3, 12'h000,    3'd0);
    cyc("addu.wb",  3'd5, RW | DONE,  3'd0);

    // lw to IO space, two data wait states: retires on cycle 7
    ir = I_LW;
    Alu_resultHigh = '1;
    cyc("lw.if",  3'd1, PW | IRW, 3'd0);
    cyc("lw.id",  3'd2, 12'h000,  3'd0);
    cyc("lw.exe", 3'd3, 12'h000,  3'd0);
    dmem_ready = 1'b0;
    cyc("lw.mem1", 3'd4, IOR, 3'd0);
    cyc("lw.mem2", 3'd4, IOR, 3'd0);
    dmem_ready = 1'b1;
    cyc("lw.mem3", 3'd4, IOR, 3'd0);
    dmem_ready = 1'b0;
    cyc("lw.wb",  3'd5, RW | DONE, 3'd0);
    Alu_resultHigh = '0;

    // div: 32 EXE cycles, start on the first, hilo_write on the last
    ir = I_DIV;
    cyc("div.if", 3'd1, PW | IRW, 3'd0);
    cyc("div.id", 3'd2, 12'h000,  3'd0);
    for (int i = 0; i < 32; i++) begin
      logic [11:0] fl;
      fl = 12'h000;
      if (i == 0)  fl = fl | MDS;
      if (i == 31) fl = fl | HW | DONE;
      cyc($sformatf("div.exe%0d", i), 3'd3, fl, 3'd0);
    end

    // beq not taken, then taken
    ir = I_BEQ;
    branch_taken = 1'b0;
    cyc("beq0.if",  3'd1, PW | IRW, 3'd0);
    cyc("beq0.id",  3'd2, 12'h000,  3'd0);
    cyc("beq0.exe", 3'd3, DONE,     3'd1);
    branch_taken = 1'b1;
    cyc("beq1.if",  3'd1, PW | IRW,  3'd0);
    cyc("beq1.id",  3'd2, 12'h000,   3'd0);
    cyc("beq1.exe", 3'd3, PW | DONE, 3'd1);
    branch_taken = 1'b0;

    // jal: jump in EXE, link in WB
    ir = I_JAL;
    cyc("jal.if",  3'd1, PW | IRW,  3'd0);
    cyc("jal.id",  3'd2, 12'h000,   3'd0);
    cyc("jal.exe", 3'd3, PW,        3'd2);
    cyc("jal.wb",  3'd5, RW | DONE, 3'd0);

    // reserved opcode -> RI exception
    ir = I_RSV;
    cyc("ri.if", 3'd1, PW | IRW, 3'd0);
    cyc("ri.id", 3'd2, 12'h000,  3'd0);
    check("ri.exc_code", 32'(exc_code), 32'd10);
    cyc("ri.exc", 3'd6, PW | EXQ, 3'd5);

    // reset mid-EXE of a jal: writes suppressed, then INIT with code cleared
    ir = I_JAL;
    cyc("rj.if", 3'd1, PW | IRW, 3'd0);
    cyc("rj.id", 3'd2, 12'h000,  3'd0);
    reset_n = 1'b0;
    cyc("rj.exe_rst", 3'd3, 12'h000, 3'd0);
    check("rj.exc_code", 32'(exc_code), 32'd0);
    cyc("rj.init_rst", 3'd0, 12'h000, 3'd0);
    reset_n = 1'b1;
    cyc("rj.init", 3'd0, 12'h000, 3'd0);

    // syscall -> Sys exception
    ir = I_SYSC;
    cyc("sys.if", 3'd1, PW | IRW, 3'd0);
    cyc("sys.id", 3'd2, 12'h000,  3'd0);
    check("sys.exc_code", 32'(exc_code), 32'd8);
    cyc("sys.exc", 3'd6, PW | EXQ, 3'd5);

    // sw to memory with an interrupt raised during its wait state
    ir = I_SW;
    cyc("sw.if",  3'd1, PW | IRW, 3'd0);
    cyc("sw.id",  3'd2, 12'h000,  3'd0);
    cyc("sw.exe", 3'd3, 12'h000,  3'd0);
    dmem_ready = 1'b0;
    int_req = 1'b1;
    int_en  = 1'b1;
    cyc("sw.mem1", 3'd4, MW, 3'd0);
    dmem_ready = 1'b1;
    cyc("sw.mem2", 3'd4, MW | DONE, 3'd0);
    dmem_ready = 1'b0;
    int_req = 1'b0;
    int_en  = 1'b0;
    check("int.exc_code", 32'(exc_code), 32'd0);
    cyc("int.exc", 3'd6, PW | EXQ, 3'd5);
    cyc("int.if",  3'd1, PW | IRW, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
